// File: rtl/hex_entry_pkg.sv
// Shared types for the keypad hex entry path: debounce states and commit actions.
package hex_entry_pkg;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;
   typedef enum logic [1:0] {ACT_NONE, ACT_DIGIT, ACT_BKSP, ACT_CLR} action_t;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous button levels, cleared by synchronous reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/hex_entry_shifter.sv
// Debounces keypad/backspace/clear levels and applies one edit per press to a
// shift register of hex digits feeding the seven-segment decoders.
module hex_entry_shifter
   import hex_entry_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int DEBOUNCE = 3
) (
   input  logic                  hz100,
   input  logic                  reset,
   input  logic [3:0]            key_code,
   input  logic                  key_valid,
   input  logic                  bksp,
   input  logic                  clr,
   output logic [4*DIGITS-1:0]   value,
   output logic [3:0]            count,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  full,
   output logic                  accept,
   output logic                  reject
);
   logic [6:0]          sync_out;
   logic [3:0]          code_s;
   logic                kv_s, bk_s, cl_s, any_s;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          pcode_q, pcode_d;
   logic [4*DIGITS-1:0] value_q, value_d;
   logic [3:0]          count_q, count_d;
   logic                accept_q, accept_d;
   logic                reject_q, reject_d;

   logic                commit;
   logic [3:0]          commit_code;
   action_t             act;

   sync2 #(.WIDTH(7)) u_sync (
      .clk   (hz100),
      .reset (reset),
      .d     ({clr, bksp, key_valid, key_code}),
      .q     (sync_out)
   );

   assign code_s = sync_out[3:0];
   assign kv_s   = sync_out[4];
   assign bk_s   = sync_out[5];
   assign cl_s   = sync_out[6];
   assign any_s  = kv_s | bk_s | cl_s;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pcode_d     = pcode_q;
      commit      = 1'b0;
      commit_code = pcode_q;
      case (state_q)
         IDLE: if (any_s) begin
            pcode_d = code_s;
            cnt_d   = CNT_W'(1);
            if (DEBOUNCE == 1) begin
               // pcode is only being latched now, so commit the live code
               commit      = 1'b1;
               commit_code = code_s;
               state_d     = HELD;
            end else begin
               state_d = ARM;
            end
         end
         ARM: begin
            if (!any_s) begin
               state_d = IDLE;
            end else if (kv_s && (code_s != pcode_q)) begin
               pcode_d = code_s;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(DEBOUNCE)) begin
                  commit  = 1'b1;
                  state_d = HELD;
               end
            end
         end
         HELD: if (!any_s) begin
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE == 1) ? IDLE : REL;
         end
         REL: begin
            if (any_s) begin
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(DEBOUNCE)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      act = ACT_NONE;
      if (commit) begin
         if (cl_s)      act = ACT_CLR;
         else if (bk_s) act = ACT_BKSP;
         else if (kv_s) act = ACT_DIGIT;
      end
   end

   always_comb begin
      value_d  = value_q;
      count_d  = count_q;
      accept_d = 1'b0;
      reject_d = 1'b0;
      case (act)
         ACT_CLR: begin
            value_d  = '0;
            count_d  = 4'd0;
            accept_d = 1'b1;
         end
         ACT_BKSP: begin
            if (count_q != 4'd0) begin
               value_d  = value_q >> 4;
               count_d  = count_q - 4'd1;
               accept_d = 1'b1;
            end else begin
               reject_d = 1'b1;
            end
         end
         ACT_DIGIT: begin
            if (count_q != 4'(DIGITS)) begin
               value_d  = {value_q[4*DIGITS-5:0], commit_code};
               count_d  = count_q + 4'd1;
               accept_d = 1'b1;
            end else begin
               reject_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge hz100) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pcode_q  <= '0;
         value_q  <= '0;
         count_q  <= '0;
         accept_q <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pcode_q  <= pcode_d;
         value_q  <= value_d;
         count_q  <= count_d;
         accept_q <= accept_d;
         reject_q <= reject_d;
      end
   end

   always_comb begin
      digit_en = '0;
      for (int i = 0; i < DIGITS; i++) digit_en[i] = (count_q > 4'(i));
   end

   assign value  = value_q;
   assign count  = count_q;
   assign full   = (count_q == 4'(DIGITS));
   assign accept = accept_q;
   assign reject = reject_q;
endmodule

// File: tb/tb_hex_entry_shifter.sv
// Bench for hex_entry_shifter: directed scenarios plus randomized presses against a digit-list model.
module tb_hex_entry_shifter;
   localparam int DIGITS   = 8;
   localparam int DEBOUNCE = 3;

   logic        hz100 = 1'b0;
   logic        reset;
   logic [3:0]  key_code;
   logic        key_valid, bksp, clr;
   logic [31:0] value;
   logic [3:0]  count;
   logic [7:0]  digit_en;
   logic        full, accept, reject;

   int n_checks = 0, n_fail = 0;
   int n_acc = 0, n_rej = 0, n_both = 0;
   logic [3:0] mq[$];

   hex_entry_shifter #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
      .hz100(hz100), .reset(reset), .key_code(key_code), .key_valid(key_valid),
      .bksp(bksp), .clr(clr), .value(value), .count(count), .digit_en(digit_en),
      .full(full), .accept(accept), .reject(reject)
   );

   always #5 hz100 = ~hz100;

   always @(negedge hz100) begin
      if (accept) n_acc++;
      if (reject) n_rej++;
      if (accept && reject) n_both++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge hz100);
      #1;
   endtask

   // Model: list of entered digits, oldest first; newest sits in value[3:0].
   function automatic logic [31:0] m_value();
      logic [31:0] v = '0;
      foreach (mq[i]) v = {v[27:0], mq[i]};
      return v;
   endfunction

   function automatic logic [7:0] m_en();
      logic [8:0] t;
      t = 9'd1 << mq.size();
      return 8'(t - 9'd1);
   endfunction

   // kind: 0 digit, 1 backspace, 2 clear, 3 clear+digit together
   task automatic model_apply(input int kind, input logic [3:0] code, output int ea, output int er);
      ea = 0; er = 0;
      case (kind)
         0: if (mq.size() < DIGITS) begin mq.push_back(code); ea = 1; end else er = 1;
         1: if (mq.size() > 0) begin void'(mq.pop_back()); ea = 1; end else er = 1;
         default: begin mq.delete(); ea = 1; end
      endcase
   endtask

   task automatic do_press(input int kind, input logic [3:0] code, input int hold, input int rel);
      key_code  = code;
      key_valid = (kind == 0 || kind == 3);
      bksp      = (kind == 1);
      clr       = (kind == 2 || kind == 3);
      step(hold);
      key_valid = 0; bksp = 0; clr = 0;
      step(rel);
   endtask

   task automatic test_reset();
      reset = 1; key_code = 0; key_valid = 0; bksp = 0; clr = 0;
      step(3);
      n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0", value); end
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (digit_en !== 8'h0 || full !== 1'b0) begin n_fail++; $display("FAIL reset_en_full: got %h/%b want 00/0", digit_en, full); end
      n_checks++; if (accept !== 1'b0 || reject !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", accept, reject); end
      reset = 0;
      mq.delete();
   endtask

   task automatic test_press();
      int a0;
      a0 = n_acc;
      key_code = 4'h5; key_valid = 1;
      step(4);
      n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h want 0 before edge 4", value); end
      step(1);
      n_checks++; if (value !== 32'h5 || count !== 4'd1) begin n_fail++; $display("FAIL press_commit: got %h/%0d want 5/1", value, count); end
      n_checks++; if (digit_en !== 8'h01) begin n_fail++; $display("FAIL press_en: got %h want 01", digit_en); end
      n_checks++; if (accept !== 1'b1) begin n_fail++; $display("FAIL press_accept: got %b want 1", accept); end
      step(1);
      n_checks++; if (accept !== 1'b0) begin n_fail++; $display("FAIL press_accept_width: got %b want 0", accept); end
      step(14);
      key_valid = 0;
      step(8);
      n_checks++; if (n_acc - a0 !== 1) begin n_fail++; $display("FAIL press_single: got %0d accepts want 1", n_acc - a0); end
      mq.push_back(4'h5);
   endtask

   task automatic test_fill();
      int ea, er, a0, r0;
      do_press(2, 0, 5, 8);
      model_apply(2, 0, ea, er);
      for (int k = 1; k <= 9; k++) begin
         a0 = n_acc; r0 = n_rej;
         do_press(0, 4'(k), 5, 8);
         model_apply(0, 4'(k), ea, er);
         n_checks++; if (value !== m_value() || count !== 4'(mq.size())) begin n_fail++; $display("FAIL fill_%0d: got %h/%0d want %h/%0d", k, value, count, m_value(), mq.size()); end
         n_checks++; if (n_acc - a0 !== ea || n_rej - r0 !== er) begin n_fail++; $display("FAIL fill_pulse_%0d: got acc%0d rej%0d want acc%0d rej%0d", k, n_acc - a0, n_rej - r0, ea, er); end
         if (k == 8) begin
            n_checks++; if (value !== 32'h12345678 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %h/%b want 12345678/1", value, full); end
         end
      end
   endtask

   task automatic test_bksp();
      int ea, er, a0, r0;
      for (int k = 0; k < 9; k++) begin
         a0 = n_acc; r0 = n_rej;
         do_press(1, 0, 5, 8);
         model_apply(1, 0, ea, er);
         n_checks++; if (value !== m_value() || count !== 4'(mq.size()) || digit_en !== m_en()) begin n_fail++; $display("FAIL bksp_%0d: got %h/%0d/%h want %h/%0d/%h", k, value, count, digit_en, m_value(), mq.size(), m_en()); end
         n_checks++; if (n_acc - a0 !== ea || n_rej - r0 !== er) begin n_fail++; $display("FAIL bksp_pulse_%0d: got acc%0d rej%0d want acc%0d rej%0d", k, n_acc - a0, n_rej - r0, ea, er); end
         if (k == 0) begin
            n_checks++; if (value !== 32'h01234567 || count !== 4'd7) begin n_fail++; $display("FAIL bksp_first: got %h/%0d want 01234567/7", value, count); end
         end
      end
   endtask

   task automatic test_glitch_bounce();
      int a0, r0;
      a0 = n_acc; r0 = n_rej;
      key_code = 4'h4; key_valid = 1;
      step(2);
      key_valid = 0;
      step(8);
      n_checks++; if (n_acc - a0 !== 0 || n_rej - r0 !== 0 || value !== 32'h0) begin n_fail++; $display("FAIL glitch: got acc%0d rej%0d val %h want 0 0 0", n_acc - a0, n_rej - r0, value); end
      a0 = n_acc;
      key_code = 4'h3; key_valid = 1; step(8);
      key_valid = 0; step(1);
      key_valid = 1; step(1);
      key_valid = 0; step(1);
      key_valid = 1; step(1);
      key_valid = 0; step(10);
      mq.push_back(4'h3);
      n_checks++; if (n_acc - a0 !== 1 || value !== 32'h3) begin n_fail++; $display("FAIL bounce: got acc%0d val %h want 1 3", n_acc - a0, value); end
   endtask

   task automatic test_code_priority();
      int ea, er, a0, r0;
      do_press(2, 0, 5, 8);
      model_apply(2, 0, ea, er);
      key_code = 4'h2; key_valid = 1; step(2);
      key_code = 4'h7; step(10);
      key_valid = 0; step(8);
      model_apply(0, 4'h7, ea, er);
      n_checks++; if (value !== 32'h7 || count !== 4'd1) begin n_fail++; $display("FAIL code_change: got %h/%0d want 7/1", value, count); end
      do_press(2, 0, 5, 8); model_apply(2, 0, ea, er);
      do_press(0, 1, 5, 8); model_apply(0, 1, ea, er);
      do_press(0, 2, 5, 8); model_apply(0, 2, ea, er);
      n_checks++; if (value !== 32'h12) begin n_fail++; $display("FAIL prio_setup: got %h want 12", value); end
      a0 = n_acc; r0 = n_rej;
      do_press(3, 4'h9, 5, 8);
      model_apply(3, 4'h9, ea, er);
      n_checks++; if (value !== 32'h0 || count !== 4'd0) begin n_fail++; $display("FAIL prio_clear: got %h/%0d want 0/0", value, count); end
      n_checks++; if (n_acc - a0 !== 1 || n_rej - r0 !== 0) begin n_fail++; $display("FAIL prio_pulse: got acc%0d rej%0d want 1 0", n_acc - a0, n_rej - r0); end
   endtask

   task automatic test_reset_mid();
      int ea, er;
      do_press(0, 4'hC, 5, 8); model_apply(0, 4'hC, ea, er);
      key_code = 4'hA; key_valid = 1;
      step(2);
      reset = 1;
      step(1);
      mq.delete();
      n_checks++; if (value !== 32'h0 || count !== 4'd0) begin n_fail++; $display("FAIL rstmid_clear: got %h/%0d want 0/0", value, count); end
      reset = 0;
      step(4);
      n_checks++; if (value !== 32'h0) begin n_fail++; $display("FAIL rstmid_early: got %h want 0", value); end
      step(1);
      n_checks++; if (value !== 32'hA || count !== 4'd1) begin n_fail++; $display("FAIL rstmid_commit: got %h/%0d want a/1", value, count); end
      step(5);
      key_valid = 0; step(8);
      mq.push_back(4'hA);
   endtask

   task automatic test_random();
      int ea, er, a0, r0, kind, r;
      logic [3:0] code;
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         kind = (r < 7) ? 0 : (r < 9) ? 1 : 2;
         code = 4'($urandom_range(0, 15));
         a0 = n_acc; r0 = n_rej;
         do_press(kind, code, $urandom_range(4, 9), $urandom_range(5, 10));
         model_apply(kind, code, ea, er);
         n_checks++; if (value !== m_value() || count !== 4'(mq.size())) begin n_fail++; $display("FAIL rand_%0d: got %h/%0d want %h/%0d", k, value, count, m_value(), mq.size()); end
         n_checks++; if (digit_en !== m_en() || full !== (mq.size() == DIGITS)) begin n_fail++; $display("FAIL rand_en_%0d: got %h/%b want %h", k, digit_en, full, m_en()); end
         n_checks++; if (n_acc - a0 !== ea || n_rej - r0 !== er) begin n_fail++; $display("FAIL rand_pulse_%0d: got acc%0d rej%0d want acc%0d rej%0d", k, n_acc - a0, n_rej - r0, ea, er); end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_fill();
      test_bksp();
      test_glitch_bounce();
      test_code_priority();
      test_reset_mid();
      test_random();
      n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL acc_rej_overlap: got %0d cycles want 0", n_both); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hex_entry_shifter.md
Name: hex_entry_shifter

Overview:
- Sits directly downstream of the 16-to-4 keypad encoder (code plus strobe) and upstream of the per-digit seven-segment decoders.
- Synchronizes and debounces raw pushbutton-derived levels, then turns each debounced press into exactly one edit of a hex digit register.
- Edits are shift-in digit, backspace and clear.
- The register and its digit enables drive ss7..ss0 in top.

Parameters:
DIGITS, 8, number of hex digits held (value width is 4*DIGITS)
DEBOUNCE, 3, consecutive stable samples needed to accept a press or a release (legal range 1..15)

Ports:
hz100  in  1  system clock
reset  in  1  synchronous, active-high reset
key_code  in  4  encoded key value (encoder out)
key_valid  in  1  level, any digit key down (encoder strobe)
bksp  in  1  level, backspace button
clr  in  1  level, clear button
value  out  4*DIGITS  entered digits; newest digit in [3:0]
count  out  4  digits currently entered, 0..DIGITS
digit_en  out  DIGITS  thermometer of count: bit i = (i < count)
full  out  1  count == DIGITS
accept  out  1  one-cycle pulse: an edit was applied
reject  out  1  one-cycle pulse: a debounced press was refused

Behaviour:
- Clock and reset: one clock, hz100. Reset is synchronous and active-high.
- Reset state: every register is cleared, including the synchronizer flops. value=0, count=0, digit_en=0, full=0, accept=0, reject=0, state IDLE, counter 0.
- Synchronizer: key_valid, bksp, clr and key_code pass through a 2-flop synchronizer. Call the synchronized signals kv_s, bk_s, cl_s, code_s. any_s = kv_s|bk_s|cl_s.
- State machine: states IDLE, ARM, HELD, REL; 4-bit counter cnt.
- IDLE:
  - any_s=1: latch code_s into pcode and set cnt=1.
  - If DEBOUNCE==1, commit on this edge and go to HELD. Otherwise go to ARM.
- ARM:
  - any_s=0: go to IDLE (glitch discarded).
  - code_s != pcode while kv_s=1: set pcode=code_s, cnt=1, stay in ARM (restart).
  - Otherwise cnt++. When cnt reaches DEBOUNCE on this edge, commit and go to HELD.
- HELD: all of kv_s, bk_s, cl_s low: set cnt=1. If DEBOUNCE==1 go to IDLE, else go to REL.
- REL:
  - any_s=1: go to HELD (release bounce, no new press).
  - Otherwise cnt++. When cnt reaches DEBOUNCE, go to IDLE.
- Commit priority (sampled at the commit edge): cl_s, then bk_s, then kv_s.
  - Clear: value=0, count=0, accept.
  - Backspace, count>0: value = value >> 4 (zero fill at top), count-1, accept.
  - Backspace, count==0: no change, reject.
  - Digit, count<DIGITS: value = {value[4*DIGITS-5:0], pcode}, count+1, accept.
  - Digit, count==DIGITS: no change, reject.
- Output timing:
  - value and count update on the commit edge.
  - accept/reject are registered, high for exactly the cycle after the commit edge, and are never both high.
  - full and digit_en are combinational from count.
- Latency: a raw input set up before edge 0 and held steady commits at edge DEBOUNCE+1.
- One hold, one action: at most one commit per press, regardless of hold length or release bounce shorter than DEBOUNCE samples.
- Buttons added mid-press: extra buttons pressed while in HELD are ignored until a full release completes.
- Reset mid-operation: any pending ARM or HELD press is discarded. A button still held after reset deasserts is debounced afresh and commits normally.

Decomposition:
- Package hex_entry_pkg:
  - state_t enum {IDLE, ARM, HELD, REL}.
  - action_t enum {ACT_NONE, ACT_DIGIT, ACT_BKSP, ACT_CLR}.
  - Constant CNT_W=4.
- Sub-module sync2: parameter WIDTH, 2-flop synchronizer with synchronous reset. Instantiated once, WIDTH=7.
- Action decode and the value/count datapath stay in the main module.

Test Plan (DIGITS=8, DEBOUNCE=3):
- Press: after reset, key_code=5, key_valid high from edge 0 for 20 cycles -> at edge 4, value=0x00000005, count=1, digit_en=0x01. accept is high for exactly one cycle, with no further accept while held.
- Fill and overflow: enter keys 1..8 with full releases between -> value=0x12345678, full=1. Then enter 9 -> reject pulse, value unchanged.
- Backspace: bksp press on 0x12345678 -> value=0x01234567, count=7. Seven more presses reach count=0; the next press gives reject, value=0.
- Glitch and bounce: key_valid high for 2 cycles then low -> no change. Hold key 3, then 1-cycle low dips during release -> exactly one accept, value=0x3.
- Code change and priority: key_code switches 2->7 after 2 cycles of hold -> 7 is entered, not 2. clr and key_valid asserted together on value 0x12 -> value=0, count=0, single accept.
- Reset mid-ARM: reset asserted 2 cycles after key press starts -> value=0 and state IDLE at that edge. With the key still held after reset, the key commits DEBOUNCE+1 edges after reset deasserts.
